// File: rtl/data_mem_ctrl.sv
// Data-memory responder for the single-cycle RV32 core: byte/half/word loads and stores
// with configurable wait states and a combinational stall. Optional macro: DMEM_MISALIGN_TRAP_EN.
module data_mem_ctrl #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        fault
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [3:0] WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
    localparam logic NO_WAIT = (WAIT_STATES == 0);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] mem [DEPTH];

    logic        req;
    logic        is_byte;
    logic        is_half;
    logic        is_word;
    logic        trap;
    logic        commit;
    logic [1:0]  lane;
    logic [AW-1:0] idx;
    logic [3:0]  be;
    logic [31:0] wbus;
    logic [31:0] rd_word;
    logic [31:0] rd_shift;
    logic [31:0] ld_ext;
    logic        unused_addr_bits;

    assign req     = mem_read | mem_write;
    assign is_byte = (funct3[1:0] == 2'b00);
    assign is_half = (funct3[1:0] == 2'b01);
    assign is_word = ~is_byte & ~is_half;
    assign idx     = addr[AW+1:2];
    assign unused_addr_bits = ^{addr[31:AW+2], funct3[2] & 1'b0};

`ifdef DMEM_MISALIGN_TRAP_EN
    assign trap = (is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00));
    assign lane = addr[1:0];
`else
    assign trap = 1'b0;
    // Misaligned accesses silently round down to the natural boundary of the access size.
    always_comb begin
        lane = addr[1:0];
        if (is_word)      lane = 2'b00;
        else if (is_half) lane = {addr[1], 1'b0};
    end
`endif

    assign stall  = rst_n & (((state == IDLE) & req) | (state == WAIT));
    assign commit = rst_n & req &
                    (((state == IDLE) & NO_WAIT) | ((state == WAIT) & (cnt == 4'd0)));

    always_comb begin
        be   = 4'b1111;
        wbus = wdata;
        if (is_byte) begin
            be   = 4'b0001 << lane;
            wbus = {4{wdata[7:0]}};
        end else if (is_half) begin
            be   = lane[1] ? 4'b1100 : 4'b0011;
            wbus = {2{wdata[15:0]}};
        end
    end

    always_comb begin
        rd_word  = mem[idx];
        rd_shift = rd_word >> {lane, 3'b000};
        ld_ext   = rd_word;
        if (is_byte)
            ld_ext = {{24{rd_shift[7] & ~funct3[2]}}, rd_shift[7:0]};
        else if (is_half)
            ld_ext = {{16{rd_shift[15] & ~funct3[2]}}, rd_shift[15:0]};
    end

    // RAM has no reset; a store only lands on the edge that enters DONE.
    always_ff @(posedge clk) begin
        if (commit & mem_write & ~trap) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wbus[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            rdata <= '0;
            fault <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        if (NO_WAIT) state <= DONE;
                        else begin
                            state <= WAIT;
                            cnt   <= WS_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) state <= DONE;
                    else             cnt   <= cnt - 4'd1;
                end
                DONE: begin
                    state <= IDLE;
                    fault <= 1'b0;
                end
                default: state <= IDLE;
            endcase
            if (commit) begin
                fault <= trap;
                if (trap)            rdata <= '0;
                else if (!mem_write) rdata <= ld_ext;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed self-checking bench for data_mem_ctrl: one instance with WAIT_STATES=1, one with 0.
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd1, wr1, rd0, wr0;
    logic [2:0]  f3_1, f3_0;
    logic [31:0] addr1, addr0, wd1, wd0;
    logic [31:0] rdata1, rdata0;
    logic        stall1, stall0, fault1, fault0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    data_mem_ctrl #(.DEPTH(1024), .WAIT_STATES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .mem_read(rd1), .mem_write(wr1), .funct3(f3_1),
        .addr(addr1), .wdata(wd1), .rdata(rdata1), .stall(stall1), .fault(fault1)
    );

    data_mem_ctrl #(.DEPTH(1024), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .mem_read(rd0), .mem_write(wr0), .funct3(f3_0),
        .addr(addr0), .wdata(wd0), .rdata(rdata0), .stall(stall0), .fault(fault0)
    );

    // Called at posedge+1; returns at posedge+1 of the IDLE cycle following DONE.
    task automatic access(input bit sel, input bit wr, input bit rd, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int stalls, output logic [31:0] res, output logic flt);
        if (sel) begin wr1 = wr; rd1 = rd; f3_1 = f3; addr1 = a; wd1 = wd; end
        else     begin wr0 = wr; rd0 = rd; f3_0 = f3; addr0 = a; wd0 = wd; end
        stalls = 0;
        #1;
        while ((sel ? stall1 : stall0) === 1'b1 && stalls < 40) begin
            stalls++;
            @(posedge clk); #1;
        end
        res = sel ? rdata1 : rdata0;
        flt = sel ? fault1 : fault0;
        @(posedge clk); #1;
        wr1 = 0; rd1 = 0; wr0 = 0; rd0 = 0;
    endtask

    task automatic test_reset;
        rst_n = 0; wr1 = 0; rd1 = 0; wr0 = 0; rd0 = 0;
        f3_1 = 3'b010; f3_0 = 3'b010; addr1 = '0; addr0 = '0; wd1 = '0; wd0 = '0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1;
        @(posedge clk); #1;
        n_cmp++; if (rdata1 !== 32'h0) begin n_bad++; $display("FAIL reset_rdata1: got %h expected %h", rdata1, 32'h0); end
        n_cmp++; if (fault1 !== 1'b0) begin n_bad++; $display("FAIL reset_fault1: got %b expected 0", fault1); end
        n_cmp++; if (stall1 !== 1'b0) begin n_bad++; $display("FAIL reset_stall1: got %b expected 0", stall1); end
        n_cmp++; if (rdata0 !== 32'h0) begin n_bad++; $display("FAIL reset_rdata0: got %h expected %h", rdata0, 32'h0); end
        n_cmp++; if (stall0 !== 1'b0) begin n_bad++; $display("FAIL reset_stall0: got %b expected 0", stall0); end
    endtask

    task automatic test_word;
        int s; logic [31:0] r; logic f;
        access(1, 1, 0, 3'b010, 32'h10, 32'hDEADBEEF, s, r, f);
        n_cmp++; if (s !== 2) begin n_bad++; $display("FAIL sw_stalls: got %0d expected 2", s); end
        n_cmp++; if (f !== 1'b0) begin n_bad++; $display("FAIL sw_fault: got %b expected 0", f); end
        access(1, 0, 1, 3'b010, 32'h10, 32'h0, s, r, f);
        n_cmp++; if (s !== 2) begin n_bad++; $display("FAIL lw_stalls: got %0d expected 2", s); end
        n_cmp++; if (r !== 32'hDEADBEEF) begin n_bad++; $display("FAIL lw_data: got %h expected %h", r, 32'hDEADBEEF); end
        n_cmp++; if (rdata1 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rdata_hold: got %h expected %h", rdata1, 32'hDEADBEEF); end
        access(1, 1, 1, 3'b010, 32'h14, 32'h01020304, s, r, f);
        n_cmp++; if (r !== 32'hDEADBEEF) begin n_bad++; $display("FAIL both_no_load: got %h expected %h", r, 32'hDEADBEEF); end
        access(1, 0, 1, 3'b010, 32'h14, 32'h0, s, r, f);
        n_cmp++; if (r !== 32'h01020304) begin n_bad++; $display("FAIL both_stored: got %h expected %h", r, 32'h01020304); end
    endtask

    task automatic test_byte;
        int s; logic [31:0] r; logic f;
        access(1, 1, 0, 3'b010, 32'h10, 32'h11223344, s, r, f);
        access(1, 1, 0, 3'b000, 32'h13, 32'hFFFFFF80, s, r, f);
        access(1, 0, 1, 3'b000, 32'h13, 32'h0, s, r, f);
        n_cmp++; if (r !== 32'hFFFFFF80) begin n_bad++; $display("FAIL lb: got %h expected %h", r, 32'hFFFFFF80); end
        access(1, 0, 1, 3'b100, 32'h13, 32'h0, s, r, f);
        n_cmp++; if (r !== 32'h00000080) begin n_bad++; $display("FAIL lbu: got %h expected %h", r, 32'h80); end
        access(1, 0, 1, 3'b010, 32'h10, 32'h0, s, r, f);
        n_cmp++; if (r !== 32'h80223344) begin n_bad++; $display("FAIL lw_after_sb: got %h expected %h", r, 32'h80223344); end
        access(1, 0, 1, 3'b000, 32'h11, 32'h0, s, r, f);
        n_cmp++; if (r !== 32'h00000033) begin n_bad++; $display("FAIL lb_pos: got %h expected %h", r, 32'h33); end
        access(1, 0, 1, 3'b111, 32'h10, 32'h0, s, r, f);
        n_cmp++; if (r !== 32'h80223344) begin n_bad++; $display("FAIL f3_111_word: got %h expected %h", r, 32'h80223344); end
    endtask

    task automatic test_half;
        int s; logic [31:0] r; logic f;
        access(1, 1, 0, 3'b010, 32'h20, 32'hAAAA5555, s, r, f);
        access(1, 1, 0, 3'b001, 32'h22, 32'h12348001, s, r, f);
        access(1, 0, 1, 3'b001, 32'h22, 32'h0, s, r, f);
        n_cmp++; if (r !== 32'hFFFF8001) begin n_bad++; $display("FAIL lh: got %h expected %h", r, 32'hFFFF8001); end
        access(1, 0, 1, 3'b101, 32'h22, 32'h0, s, r, f);
        n_cmp++; if (r !== 32'h00008001) begin n_bad++; $display("FAIL lhu: got %h expected %h", r, 32'h8001); end
        access(1, 0, 1, 3'b001, 32'h20, 32'h0, s, r, f);
        n_cmp++; if (r !== 32'h00005555) begin n_bad++; $display("FAIL lh_low: got %h expected %h", r, 32'h5555); end
        access(1, 0, 1, 3'b010, 32'h20, 32'h0, s, r, f);
        n_cmp++; if (r !== 32'h80015555) begin n_bad++; $display("FAIL lw_after_sh: got %h expected %h", r, 32'h80015555); end
    endtask

    task automatic test_wrap;
        int s; logic [31:0] r; logic f;
        access(1, 0, 1, 3'b010, 32'hF000_1010, 32'h0, s, r, f);
        n_cmp++; if (r !== 32'h80223344) begin n_bad++; $display("FAIL addr_wrap: got %h expected %h", r, 32'h80223344); end
    endtask

    task automatic test_reset_mid_wait;
        int s; logic [31:0] r; logic f;
        access(1, 1, 0, 3'b010, 32'h40, 32'h0BADF00D, s, r, f);
        wr1 = 1; rd1 = 0; f3_1 = 3'b010; addr1 = 32'h40; wd1 = 32'h12345678;
        @(posedge clk); #1;
        n_cmp++; if (stall1 !== 1'b1) begin n_bad++; $display("FAIL wait_stall: got %b expected 1", stall1); end
        rst_n = 0;
        #1;
        n_cmp++; if (stall1 !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %b expected 0", stall1); end
        wr1 = 0;
        #1 rst_n = 1;
        @(posedge clk); #1;
        n_cmp++; if (stall1 !== 1'b0) begin n_bad++; $display("FAIL post_rst_idle: got %b expected 0", stall1); end
        n_cmp++; if (rdata1 !== 32'h0) begin n_bad++; $display("FAIL post_rst_rdata: got %h expected 0", rdata1); end
        access(1, 0, 1, 3'b010, 32'h40, 32'h0, s, r, f);
        n_cmp++; if (r !== 32'h0BADF00D) begin n_bad++; $display("FAIL store_discarded: got %h expected %h", r, 32'h0BADF00D); end
        n_cmp++; if (s !== 2) begin n_bad++; $display("FAIL post_rst_stalls: got %0d expected 2", s); end
    endtask

    task automatic test_misalign;
        int s; logic [31:0] r; logic f;
        logic        exp_f;
        logic [31:0] exp_w, exp_lh, exp_lb;
`ifdef DMEM_MISALIGN_TRAP_EN
        exp_f = 1'b1; exp_w = 32'h0BADF00D; exp_lh = 32'h0; exp_lb = 32'hFFFFFFF0;
`else
        exp_f = 1'b0; exp_w = 32'hCAFE0001; exp_lh = 32'hFFFF8001; exp_lb = 32'h00000000;
`endif
        access(1, 1, 0, 3'b010, 32'h41, 32'hCAFE0001, s, r, f);
        n_cmp++; if (f !== exp_f) begin n_bad++; $display("FAIL sw_mis_fault: got %b expected %b", f, exp_f); end
        n_cmp++; if (s !== 2) begin n_bad++; $display("FAIL sw_mis_stalls: got %0d expected 2", s); end
        n_cmp++; if (fault1 !== 1'b0) begin n_bad++; $display("FAIL fault_clear: got %b expected 0", fault1); end
        access(1, 0, 1, 3'b010, 32'h40, 32'h0, s, r, f);
        n_cmp++; if (r !== exp_w) begin n_bad++; $display("FAIL sw_mis_word: got %h expected %h", r, exp_w); end
        access(1, 0, 1, 3'b001, 32'h23, 32'h0, s, r, f);
        n_cmp++; if (r !== exp_lh) begin n_bad++; $display("FAIL lh_mis_data: got %h expected %h", r, exp_lh); end
        n_cmp++; if (f !== exp_f) begin n_bad++; $display("FAIL lh_mis_fault: got %b expected %b", f, exp_f); end
        access(1, 0, 1, 3'b000, 32'h41, 32'h0, s, r, f);
        n_cmp++; if (r !== exp_lb) begin n_bad++; $display("FAIL lb_odd: got %h expected %h", r, exp_lb); end
        n_cmp++; if (f !== 1'b0) begin n_bad++; $display("FAIL lb_odd_fault: got %b expected 0", f); end
    endtask

    task automatic test_ws0;
        int s; logic [31:0] r; logic f;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (stall0 !== 1'b0) begin n_bad++; $display("FAIL ws0_idle_stall: got %b expected 0", stall0); end
        end
        access(0, 1, 0, 3'b010, 32'h8, 32'h000055AA, s, r, f);
        n_cmp++; if (s !== 1) begin n_bad++; $display("FAIL ws0_sw_stalls: got %0d expected 1", s); end
        access(0, 0, 1, 3'b010, 32'h8, 32'h0, s, r, f);
        n_cmp++; if (s !== 1) begin n_bad++; $display("FAIL ws0_lw_stalls: got %0d expected 1", s); end
        n_cmp++; if (r !== 32'h000055AA) begin n_bad++; $display("FAIL ws0_lw_data: got %h expected %h", r, 32'h55AA); end
        access(0, 0, 1, 3'b000, 32'h8, 32'h0, s, r, f);
        n_cmp++; if (r !== 32'hFFFFFFAA) begin n_bad++; $display("FAIL ws0_lb: got %h expected %h", r, 32'hFFFFFFAA); end
    endtask

    task automatic test_back_to_back;
        int s1, s2, c0; logic [31:0] r; logic f;
        c0 = cyc;
        access(1, 1, 0, 3'b010, 32'h80, 32'hA5A5C3C3, s1, r, f);
        access(1, 0, 1, 3'b010, 32'h80, 32'h0, s2, r, f);
        n_cmp++; if (s1 !== 2 || s2 !== 2) begin n_bad++; $display("FAIL b2b_stalls: got %0d/%0d expected 2/2", s1, s2); end
        n_cmp++; if (cyc - c0 !== 6) begin n_bad++; $display("FAIL b2b_cycles: got %0d expected 6", cyc - c0); end
        n_cmp++; if (r !== 32'hA5A5C3C3) begin n_bad++; $display("FAIL b2b_data: got %h expected %h", r, 32'hA5A5C3C3); end
    endtask

    initial begin
        test_reset;
        test_word;
        test_byte;
        test_half;
        test_wrap;
        test_reset_mid_wait;
        test_misalign;
        test_ws0;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
